secded_rx_pair_ctrl: RTL and testbench

- Sits between the UART receiver core and the RX FIFO in the receive path.
- Pairs consecutive received bytes into a low and a high Hamming(8,4) SEC-DED codeword.
- Decodes and corrects each codeword, joins the two nibbles into one data byte, and pushes a 10-bit word {flags, byte} into the FIFO.
- Sequences pairing, inter-byte timeout, overflow handling and sticky error status.

---
 rtl/secded_rx_pair_ctrl_pkg.sv | 39 +++
 rtl/secded_rx_pair_ctrl_if.sv | 30 +++
 rtl/secded_rx_pair_ctrl_dec.sv | 38 +++
 rtl/secded_rx_pair_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_secded_rx_pair_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/secded_rx_pair_ctrl_pkg.sv
// Shared constants, FSM encoding and SEC-DED helpers for the paired-codeword
// receive controller.
package secded_rx_pair_ctrl_pkg;

    localparam int unsigned CW_P1 = 0;
    localparam int unsigned CW_P2 = 1;
    localparam int unsigned CW_D0 = 2;
    localparam int unsigned CW_P4 = 3;
    localparam int unsigned CW_D1 = 4;
    localparam int unsigned CW_D2 = 5;
    localparam int unsigned CW_D3 = 6;
    localparam int unsigned CW_P0 = 7;

    localparam int unsigned BYTE_LSB = 0;
    localparam int unsigned COR_BIT  = 8;
    localparam int unsigned DBL_BIT  = 9;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_DECODE    = 2'd2,
        ST_WRITE     = 2'd3
    } state_e;

    function automatic logic [2:0] secded_syndrome(input logic [7:0] cw);
        logic s1;
        logic s2;
        logic s4;
        s1 = cw[CW_P1] ^ cw[CW_D0] ^ cw[CW_D1] ^ cw[CW_D3];
        s2 = cw[CW_P2] ^ cw[CW_D0] ^ cw[CW_D2] ^ cw[CW_D3];
        s4 = cw[CW_P4] ^ cw[CW_D1] ^ cw[CW_D2] ^ cw[CW_D3];
        return {s4, s2, s1};
    endfunction

    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/secded_rx_pair_ctrl_if.sv
// Bundles the UART-side, FIFO-side and status signals of the pair controller.
interface secded_rx_pair_ctrl_if #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned CNT_W     = 8
);
    logic                   s_tick;
    logic                   rx_done;
    logic [DATA_SIZE-1:0]   rx_byte;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [DATA_SIZE+1:0]   fifo_wr_data;
    logic                   pair_timeout;
    logic                   stat_clr;
    logic [2:0]             rx_status;
    logic [CNT_W-1:0]       corr_cnt;
    logic [CNT_W-1:0]       derr_cnt;
    logic                   busy;

    modport slave (
        input  s_tick, rx_done, rx_byte, fifo_full, stat_clr,
        output fifo_wr_en, fifo_wr_data, pair_timeout, rx_status,
               corr_cnt, derr_cnt, busy
    );

    modport master (
        output s_tick, rx_done, rx_byte, fifo_full, stat_clr,
        input  fifo_wr_en, fifo_wr_data, pair_timeout, rx_status,
               corr_cnt, derr_cnt, busy
    );
endinterface

// File: rtl/secded_rx_pair_ctrl_dec.sv
// Hamming(8,4) SEC-DED decoder: corrects single errors, flags double errors
// and extracts the data nibble.
module secded84_dec
    import secded_rx_pair_ctrl_pkg::*;
(
    input  logic [7:0] cw_i,
    output logic [3:0] nibble_o,
    output logic       corrected_o,
    output logic       double_err_o
);
    logic [2:0] syn_s;
    logic       par_s;
    logic [7:0] flip_s;
    logic [7:0] fixed_s;

    // Classify the codeword; syndrome 0 with odd parity means p0 itself flipped.
    always_comb begin
        syn_s        = secded_syndrome(cw_i);
        par_s        = cw_i[CW_P0] ^ (^cw_i[CW_D3:CW_P1]);
        flip_s       = 8'h00;
        corrected_o  = 1'b0;
        double_err_o = 1'b0;
        if (par_s) begin
            corrected_o = 1'b1;
            if (syn_s != 3'd0) begin
                flip_s = 8'h01 << (syn_s - 3'd1);
            end else begin
                flip_s = 8'h00;
            end
        end else if (syn_s != 3'd0) begin
            double_err_o = 1'b1;
        end else begin
            double_err_o = 1'b0;
        end
        fixed_s  = cw_i ^ flip_s;
        nibble_o = {fixed_s[CW_D3], fixed_s[CW_D2], fixed_s[CW_D1], fixed_s[CW_D0]};
    end
endmodule

// File: rtl/secded_rx_pair_ctrl.sv
// Pairs received SEC-DED codewords into data bytes, writes {flags, byte} into
// the RX FIFO and keeps sticky error status and saturating counters.
module secded_rx_pair_ctrl
    import secded_rx_pair_ctrl_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned SAMPLE       = 16,
    parameter int unsigned TIMEOUT_BITS = 20,
    parameter int unsigned CNT_W        = 8
)(
    input logic                  clk,
    input logic                  reset_n,
    secded_rx_pair_ctrl_if.slave bus
);
    localparam int unsigned TICK_LIMIT = SAMPLE * TIMEOUT_BITS;
    localparam int unsigned TICK_W     = $clog2(TICK_LIMIT + 1);

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] low_q, low_d, high_q, high_d, byte_q, byte_d;
    logic                 pend_q, pend_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [1:0]           cor_q, cor_d, dbl_q, dbl_d;
    logic [CNT_W-1:0]     corr_cnt_q, corr_cnt_d, derr_cnt_q, derr_cnt_d;
    logic [CNT_W-1:0]     corr_base_s, derr_base_s;
    logic [2:0]           status_q, status_d;
    logic                 timeout_q, timeout_d, busy_q, busy_d;
    logic                 write_s, wr_en_s, expire_s, timeout_s;
    logic [3:0]           nib_l_s, nib_h_s;
    logic                 cor_l_s, cor_h_s, dbl_l_s, dbl_h_s;
    logic [DATA_SIZE+1:0] word_s;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return '1;
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    secded84_dec u_dec_lo (.cw_i(low_q),  .nibble_o(nib_l_s), .corrected_o(cor_l_s), .double_err_o(dbl_l_s));
    secded84_dec u_dec_hi (.cw_i(high_q), .nibble_o(nib_h_s), .corrected_o(cor_h_s), .double_err_o(dbl_h_s));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a high byte arriving on the expiry cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      state_d = bus.rx_done ? ST_WAIT_HIGH : ST_IDLE;
            ST_WAIT_HIGH: begin
                if (bus.rx_done) begin
                    state_d = ST_DECODE;
                end else if (expire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_DECODE:    state_d = ST_WRITE;
            ST_WRITE:     state_d = (pend_q || bus.rx_done) ? ST_WAIT_HIGH : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; the FIFO strobe follows fifo_full within the WRITE cycle.
    always_comb begin
        write_s   = (state_q == ST_WRITE);
        wr_en_s   = write_s && !bus.fifo_full;
        expire_s  = (state_q == ST_WAIT_HIGH) && (tick_q == TICK_W'(TICK_LIMIT));
        timeout_s = expire_s && !bus.rx_done;
    end

    // Datapath next state: byte capture, timer, decode results, counters, status.
    always_comb begin
        low_d    = low_q;
        high_d   = high_q;
        pend_d   = pend_q;
        tick_d   = '0;
        byte_d   = byte_q;
        cor_d    = cor_q;
        dbl_d    = dbl_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_done) begin
                    low_d = bus.rx_byte;
                end else begin
                    low_d = low_q;
                end
            end
            ST_WAIT_HIGH: begin
                tick_d = tick_q;
                if (bus.s_tick && (tick_q != TICK_W'(TICK_LIMIT))) begin
                    tick_d = tick_q + TICK_W'(1);
                end else begin
                    tick_d = tick_q;
                end
                if (bus.rx_done) begin
                    high_d = bus.rx_byte;
                end else if (expire_s) begin
                    low_d = '0;
                end else begin
                    high_d = high_q;
                end
            end
            ST_DECODE: begin
                byte_d = {nib_h_s, nib_l_s};
                cor_d  = {cor_h_s, cor_l_s};
                dbl_d  = {dbl_h_s, dbl_l_s};
                // A byte landing here becomes the next low codeword.
                if (bus.rx_done) begin
                    low_d  = bus.rx_byte;
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
            end
            ST_WRITE: begin
                pend_d = 1'b0;
                if (bus.rx_done) begin
                    low_d = bus.rx_byte;
                end else begin
                    low_d = low_q;
                end
            end
            default: begin
                pend_d = 1'b0;
            end
        endcase

        corr_base_s = bus.stat_clr ? '0 : corr_cnt_q;
        derr_base_s = bus.stat_clr ? '0 : derr_cnt_q;
        if (write_s) begin
            corr_cnt_d = sat_add(corr_base_s, pop2(cor_q));
            derr_cnt_d = sat_add(derr_base_s, pop2(dbl_q));
        end else begin
            corr_cnt_d = corr_base_s;
            derr_cnt_d = derr_base_s;
        end
        status_d  = (bus.stat_clr ? 3'b000 : status_q)
                  | (write_s ? {bus.fifo_full, |dbl_q, |cor_q} : 3'b000);
        timeout_d = timeout_s;
        busy_d    = (state_d != ST_IDLE);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            low_q      <= '0;
            high_q     <= '0;
            pend_q     <= 1'b0;
            tick_q     <= '0;
            byte_q     <= '0;
            cor_q      <= 2'b00;
            dbl_q      <= 2'b00;
            corr_cnt_q <= '0;
            derr_cnt_q <= '0;
            status_q   <= 3'b000;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            low_q      <= low_d;
            high_q     <= high_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            byte_q     <= byte_d;
            cor_q      <= cor_d;
            dbl_q      <= dbl_d;
            corr_cnt_q <= corr_cnt_d;
            derr_cnt_q <= derr_cnt_d;
            status_q   <= status_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    // FIFO word assembly from the registered decode results.
    always_comb begin
        word_s                        = '0;
        word_s[BYTE_LSB +: DATA_SIZE] = byte_q;
        word_s[COR_BIT]               = |cor_q;
        word_s[DBL_BIT]               = |dbl_q;
    end

    assign bus.fifo_wr_en   = wr_en_s;
    assign bus.fifo_wr_data = word_s;
    assign bus.pair_timeout = timeout_q;
    assign bus.rx_status    = status_q;
    assign bus.corr_cnt     = corr_cnt_q;
    assign bus.derr_cnt     = derr_cnt_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_secded_rx_pair_ctrl.sv
// Directed, table-driven bench for the SEC-DED pair controller.
module tb_secded_rx_pair_ctrl;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_bad;
    logic seen;

    secded_rx_pair_ctrl_if #(.DATA_SIZE(8), .CNT_W(8)) bus ();

    secded_rx_pair_ctrl #(.DATA_SIZE(8), .SAMPLE(16), .TIMEOUT_BITS(20), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       full;
        logic [9:0] word;
        logic       wr;
        logic [7:0] corr;
        logic [7:0] derr;
        logic [2:0] st;
    } vec_t;

    vec_t tbl [14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d miscompares so far, required completion", n_bad);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        bus.stat_clr = 1'b1;
        cyc();
        bus.stat_clr = 1'b0;
    endtask

    task automatic run_pair(input logic [7:0] lo, input logic [7:0] hi, input logic full,
                            input logic clr_w, input logic [9:0] exp_word, input logic exp_wr,
                            input string tag);
        bus.fifo_full = full;
        bus.rx_done   = 1'b1;
        bus.rx_byte   = lo;
        cyc();
        bus.rx_done   = 1'b0;
        cyc();
        cyc();
        bus.rx_done   = 1'b1;
        bus.rx_byte   = hi;
        cyc();
        bus.rx_done   = 1'b0;
        chk({tag, " wr_en in DECODE"}, 32'(bus.fifo_wr_en), 32'd0);
        cyc();
        bus.stat_clr  = clr_w;
        chk({tag, " wr_en in WRITE"}, 32'(bus.fifo_wr_en), 32'(exp_wr));
        chk({tag, " wr_data"}, 32'(bus.fifo_wr_data), 32'(exp_word));
        cyc();
        bus.stat_clr  = 1'b0;
        bus.fifo_full = 1'b0;
        chk({tag, " wr_en after WRITE"}, 32'(bus.fifo_wr_en), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //           lo     hi     full  word     wr    corr  derr  status
        tbl[0]  = '{8'h66, 8'hE1, 1'b0, 10'h0CD, 1'b1, 8'd0, 8'd0, 3'b000};
        tbl[1]  = '{8'hE6, 8'hE1, 1'b0, 10'h1CD, 1'b1, 8'd1, 8'd0, 3'b001};
        tbl[2]  = '{8'h66, 8'hE2, 1'b0, 10'h2CD, 1'b1, 8'd0, 8'd1, 3'b010};
        tbl[3]  = '{8'h62, 8'hE1, 1'b0, 10'h1CD, 1'b1, 8'd1, 8'd0, 3'b001};
        tbl[4]  = '{8'hE6, 8'hF1, 1'b0, 10'h1CD, 1'b1, 8'd2, 8'd0, 3'b001};
        tbl[5]  = '{8'hF6, 8'hE1, 1'b0, 10'h2CF, 1'b1, 8'd0, 8'd1, 3'b010};
        tbl[6]  = '{8'hF6, 8'hE2, 1'b0, 10'h2CF, 1'b1, 8'd0, 8'd2, 3'b010};
        tbl[7]  = '{8'h00, 8'hFF, 1'b0, 10'h0F0, 1'b1, 8'd0, 8'd0, 3'b000};
        tbl[8]  = '{8'hFF, 8'h00, 1'b0, 10'h00F, 1'b1, 8'd0, 8'd0, 3'b000};
        tbl[9]  = '{8'hD2, 8'h2D, 1'b0, 10'h05A, 1'b1, 8'd0, 8'd0, 3'b000};
        tbl[10] = '{8'hD2, 8'h6D, 1'b0, 10'h15A, 1'b1, 8'd1, 8'd0, 3'b001};
        tbl[11] = '{8'h03, 8'h00, 1'b0, 10'h200, 1'b1, 8'd0, 8'd1, 3'b010};
        tbl[12] = '{8'h66, 8'hE1, 1'b1, 10'h0CD, 1'b0, 8'd0, 8'd0, 3'b100};
        tbl[13] = '{8'hE6, 8'hE2, 1'b1, 10'h3CD, 1'b0, 8'd1, 8'd1, 3'b111};

        bus.s_tick    = 1'b0;
        bus.rx_done   = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.fifo_full = 1'b0;
        bus.stat_clr  = 1'b0;
        reset_n       = 1'b0;
        cyc();
        cyc();
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("reset wr_data", 32'(bus.fifo_wr_data), 32'd0);
        chk("reset status", 32'(bus.rx_status), 32'd0);
        chk("reset counters", {16'd0, bus.corr_cnt, bus.derr_cnt}, 32'd0);
        reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 14; i++) begin
            clr();
            run_pair(tbl[i].lo, tbl[i].hi, tbl[i].full, 1'b0, tbl[i].word, tbl[i].wr, $sformatf("v%0d", i));
            chk($sformatf("v%0d corr_cnt", i), 32'(bus.corr_cnt), 32'(tbl[i].corr));
            chk($sformatf("v%0d derr_cnt", i), 32'(bus.derr_cnt), 32'(tbl[i].derr));
            chk($sformatf("v%0d rx_status", i), 32'(bus.rx_status), 32'(tbl[i].st));
            chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'd0);
        end

        // stat_clr coinciding with WRITE: old status/counts cleared, new event kept
        run_pair(8'hE6, 8'hE1, 1'b0, 1'b1, 10'h1CD, 1'b1, "clr+set");
        chk("clr+set corr_cnt", 32'(bus.corr_cnt), 32'd1);
        chk("clr+set derr_cnt", 32'(bus.derr_cnt), 32'd0);
        chk("clr+set rx_status", 32'(bus.rx_status), 32'b001);

        // timeout: 320 ticks with no high byte drops the low byte
        clr();
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'h66;
        cyc();
        bus.rx_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 320; i++) begin
            bus.s_tick = 1'b1;
            cyc();
            if (bus.pair_timeout || bus.fifo_wr_en) seen = 1'b1;
        end
        bus.s_tick = 1'b0;
        chk("timeout not early", 32'(seen), 32'd0);
        chk("timeout busy at limit", 32'(bus.busy), 32'd1);
        cyc();
        chk("timeout pulse", 32'(bus.pair_timeout), 32'd1);
        chk("timeout busy after", 32'(bus.busy), 32'd0);
        chk("timeout no write", 32'(bus.fifo_wr_en), 32'd0);
        cyc();
        chk("timeout one cycle", 32'(bus.pair_timeout), 32'd0);
        run_pair(8'h66, 8'hE1, 1'b0, 1'b0, 10'h0CD, 1'b1, "after timeout");

        // high byte on the expiry cycle beats the timeout
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'hD2;
        cyc();
        bus.rx_done = 1'b0;
        for (int i = 0; i < 320; i++) begin
            bus.s_tick = 1'b1;
            cyc();
        end
        bus.s_tick  = 1'b0;
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'h2D;
        cyc();
        bus.rx_done = 1'b0;
        chk("race no timeout", 32'(bus.pair_timeout), 32'd0);
        cyc();
        chk("race wr_en", 32'(bus.fifo_wr_en), 32'd1);
        chk("race wr_data", 32'(bus.fifo_wr_data), 32'h05A);
        cyc();
        chk("race no late timeout", 32'(bus.pair_timeout), 32'd0);

        // rx_done during DECODE becomes the next low byte
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'h66;
        cyc();
        bus.rx_done = 1'b0;
        cyc();
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'hE1;
        cyc();
        bus.rx_byte = 8'hD2;
        cyc();
        bus.rx_done = 1'b0;
        chk("b2b decode wr_data", 32'(bus.fifo_wr_data), 32'h0CD);
        chk("b2b decode wr_en", 32'(bus.fifo_wr_en), 32'd1);
        cyc();
        chk("b2b decode pending busy", 32'(bus.busy), 32'd1);
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'h2D;
        cyc();
        bus.rx_done = 1'b0;
        cyc();
        chk("b2b decode second word", 32'(bus.fifo_wr_data), 32'h05A);
        chk("b2b decode second wr_en", 32'(bus.fifo_wr_en), 32'd1);
        cyc();
        chk("b2b decode idle", 32'(bus.busy), 32'd0);

        // rx_done during WRITE becomes the next low byte
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'h66;
        cyc();
        bus.rx_done = 1'b0;
        cyc();
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'hE1;
        cyc();
        bus.rx_done = 1'b0;
        cyc();
        chk("b2b write wr_data", 32'(bus.fifo_wr_data), 32'h0CD);
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'hD2;
        cyc();
        bus.rx_done = 1'b0;
        chk("b2b write pending busy", 32'(bus.busy), 32'd1);
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'h6D;
        cyc();
        bus.rx_done = 1'b0;
        cyc();
        chk("b2b write second word", 32'(bus.fifo_wr_data), 32'h15A);
        cyc();

        // saturation of corr_cnt at 255 with two corrections per pair
        clr();
        for (int i = 1; i <= 129; i++) begin
            run_pair(8'hE6, 8'hF1, 1'b0, 1'b0, 10'h1CD, 1'b1, "sat");
            if (i == 127) chk("sat corr 254", 32'(bus.corr_cnt), 32'd254);
            if (i == 128) chk("sat corr 255", 32'(bus.corr_cnt), 32'd255);
        end
        chk("sat corr held", 32'(bus.corr_cnt), 32'd255);
        chk("sat derr", 32'(bus.derr_cnt), 32'd0);

        // asynchronous reset while waiting for the high byte
        bus.rx_done = 1'b1;
        bus.rx_byte = 8'h66;
        cyc();
        bus.rx_done = 1'b0;
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset busy", 32'(bus.busy), 32'd0);
        chk("async reset wr_data", 32'(bus.fifo_wr_data), 32'd0);
        chk("async reset counters", {16'd0, bus.corr_cnt, bus.derr_cnt}, 32'd0);
        chk("async reset status", 32'(bus.rx_status), 32'd0);
        chk("async reset wr_en/timeout", {30'd0, bus.fifo_wr_en, bus.pair_timeout}, 32'd0);
        #2 reset_n = 1'b1;
        cyc();
        run_pair(8'hD2, 8'h2D, 1'b0, 1'b0, 10'h05A, 1'b1, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
